// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM single-port bus arbiter.
// Holds the FSM state encoding, owner ids, stall vectors and the stall priority helper.
package bus_arbiter_pkg;

    localparam int STALL_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } arb_owner_t;

    // Stall bit order is {wb,mem,ex,id,if,pc}
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

    function automatic logic [STALL_W-1:0] stall_vec(input logic pend_mem, input logic pend_if);
        if (pend_mem) begin
            return STALL_MEM;
        end
        if (pend_if) begin
            return STALL_IF;
        end
        return STALL_NONE;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Requester and memory-bus signal bundle for the arbiter.
// The master modport is the arbiter's view; slave is the view of the requesters plus memory.
interface bus_arbiter_if
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                if_req_i;
    logic [ADDR_W-1:0]   if_addr_i;
    logic [DATA_W-1:0]   if_rdata_o;
    logic                if_ack_o;

    logic                mem_req_i;
    logic                mem_we_i;
    logic [3:0]          mem_sel_i;
    logic [ADDR_W-1:0]   mem_addr_i;
    logic [DATA_W-1:0]   mem_wdata_i;
    logic [DATA_W-1:0]   mem_rdata_o;
    logic                mem_ack_o;

    logic                bus_req_o;
    logic                bus_we_o;
    logic [3:0]          bus_sel_o;
    logic [ADDR_W-1:0]   bus_addr_o;
    logic [DATA_W-1:0]   bus_wdata_o;
    logic [DATA_W-1:0]   bus_rdata_i;
    logic                bus_ack_i;

    logic [STALL_W-1:0]  stall_o;
    logic                bus_err_o;

    modport master (
        input  if_req_i, if_addr_i,
        input  mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
        input  bus_rdata_i, bus_ack_i,
        output if_rdata_o, if_ack_o, mem_rdata_o, mem_ack_o,
        output bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
        output stall_o, bus_err_o
    );

    modport slave (
        output if_req_i, if_addr_i,
        output mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
        output bus_rdata_i, bus_ack_i,
        input  if_rdata_o, if_ack_o, mem_rdata_o, mem_ack_o,
        input  bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
        input  stall_o, bus_err_o
    );

endinterface

// File: rtl/bus_arbiter_timer.sv
// Wait-state watchdog counter: counts enabled cycles, saturates at MAX_WAIT.
// o_expired is high while the count sits at MAX_WAIT.
module arb_wait_timer #(
    parameter  int MAX_WAIT = 15,
    localparam int CNT_W    = $clog2(MAX_WAIT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [CNT_W-1:0] o_count,
    output logic             o_expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count   = r_count;
    assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates one single-port memory bus between instruction fetch and data access,
// one transaction at a time, driving the pipeline stall vector and a wait watchdog.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.master bus
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    arb_owner_t         r_owner;

    logic               r_bus_req;
    logic               r_bus_we;
    logic [3:0]         r_bus_sel;
    logic [ADDR_W-1:0]  r_bus_addr;
    logic [DATA_W-1:0]  r_bus_wdata;
    logic               r_bus_err;
    logic [DATA_W-1:0]  r_if_rdata;
    logic [DATA_W-1:0]  r_mem_rdata;

    logic               w_grant;
    logic               w_grant_mem;
    logic               w_finish;
    logic               w_timeout;
    logic               w_tmr_en;
    logic               w_tmr_clear;
    logic               w_expired;
    logic [CNT_W-1:0]   w_wait_cnt;
    logic [DATA_W-1:0]  w_cap_data;
    logic               w_pend_if;
    logic               w_pend_mem;
    logic               w_if_ack;
    logic               w_mem_ack;

    // Data access has priority; in IDLE a raised req is always a pending one.
    assign w_grant     = (r_state == ST_IDLE) && (bus.mem_req_i || bus.if_req_i);
    assign w_grant_mem = (r_state == ST_IDLE) && bus.mem_req_i;
    assign w_finish    = (r_state == ST_BUSY) && (bus.bus_ack_i || w_expired);
    assign w_timeout   = (r_state == ST_BUSY) && !bus.bus_ack_i && w_expired;

    // Counter is loaded to 1 on grant so it equals the number of BUSY cycles seen so far.
    assign w_tmr_en    = w_grant || (r_state == ST_BUSY);
    assign w_tmr_clear = !w_tmr_en;

    arb_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_tmr_clear),
        .i_enable  (w_tmr_en),
        .o_count   (w_wait_cnt),
        .o_expired (w_expired)
    );

    always_comb begin
        assert (w_wait_cnt <= CNT_W'(MAX_WAIT));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_if_ack    = 1'b0;
        w_mem_ack   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_finish) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_if_ack    = (r_owner == OWN_IF);
                w_mem_ack   = (r_owner == OWN_MEM);
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Stores and timeouts return zero to the owner.
    assign w_cap_data = (bus.bus_ack_i && !r_bus_we) ? bus.bus_rdata_i : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner     <= OWN_IF;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_sel   <= '0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_err   <= 1'b0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
        end else begin
            r_bus_err <= 1'b0;
            if (w_grant) begin
                r_owner     <= w_grant_mem ? OWN_MEM : OWN_IF;
                r_bus_req   <= 1'b1;
                r_bus_we    <= w_grant_mem ? bus.mem_we_i    : 1'b0;
                r_bus_sel   <= w_grant_mem ? bus.mem_sel_i   : 4'hF;
                r_bus_addr  <= w_grant_mem ? bus.mem_addr_i  : bus.if_addr_i;
                r_bus_wdata <= w_grant_mem ? bus.mem_wdata_i : '0;
            end else if (w_finish) begin
                r_bus_req <= 1'b0;
                r_bus_we  <= 1'b0;
                r_bus_err <= w_timeout;
                if (r_owner == OWN_MEM) begin
                    r_mem_rdata <= w_cap_data;
                end else begin
                    r_if_rdata  <= w_cap_data;
                end
            end
        end
    end

    // Pending masks out the owner in its ack cycle; reset silences stall at once.
    assign w_pend_mem = rst && bus.mem_req_i && !((r_state == ST_DONE) && (r_owner == OWN_MEM));
    assign w_pend_if  = rst && bus.if_req_i  && !((r_state == ST_DONE) && (r_owner == OWN_IF));

    assign bus.stall_o     = stall_vec(w_pend_mem, w_pend_if);
    assign bus.if_ack_o    = w_if_ack;
    assign bus.mem_ack_o   = w_mem_ack;
    assign bus.if_rdata_o  = r_if_rdata;
    assign bus.mem_rdata_o = r_mem_rdata;
    assign bus.bus_req_o   = r_bus_req;
    assign bus.bus_we_o    = r_bus_we;
    assign bus.bus_sel_o   = r_bus_sel;
    assign bus.bus_addr_o  = r_bus_addr;
    assign bus.bus_wdata_o = r_bus_wdata;
    assign bus.bus_err_o   = r_bus_err;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter with a configurable wait-state slave.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifc ();

    bus_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_WAIT (15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          slave_wait = 0;
    int          s_cnt = 0;
    int          n;
    logic        slave_dead = 1'b0;
    logic        stray_ack = 1'b0;
    logic [31:0] slave_rdata = 32'h0;

    // Slave acks after slave_wait extra BUSY cycles; rdata is garbage when not acking.
    always @(posedge clk) s_cnt <= ifc.bus_req_o ? s_cnt + 1 : 0;
    assign ifc.bus_ack_i   = stray_ack | (ifc.bus_req_o & ~slave_dead & (s_cnt >= slave_wait));
    assign ifc.bus_rdata_i = ifc.bus_ack_i ? slave_rdata : 32'hBAD0_BAD0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst             = 1'b0;
        ifc.if_req_i    = 1'b0;
        ifc.if_addr_i   = '0;
        ifc.mem_req_i   = 1'b0;
        ifc.mem_we_i    = 1'b0;
        ifc.mem_sel_i   = '0;
        ifc.mem_addr_i  = '0;
        ifc.mem_wdata_i = '0;
        #3;
        chk("rst_bus_req", ifc.bus_req_o, 0);
        chk("rst_stall", ifc.stall_o, STALL_NONE);
        chk("rst_if_ack", ifc.if_ack_o, 0);
        chk("rst_mem_ack", ifc.mem_ack_o, 0);
        chk("rst_err", ifc.bus_err_o, 0);
        chk("rst_if_rdata", ifc.if_rdata_o, 0);
        chk("rst_mem_rdata", ifc.mem_rdata_o, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Zero-wait fetch
        ifc.if_req_i  = 1'b1;
        ifc.if_addr_i = 32'h100;
        slave_rdata   = 32'h3C01ABCD;
        slave_wait    = 0;
        #1;
        chk("t1_stall_n", ifc.stall_o, STALL_IF);
        chk("t1_breq_n", ifc.bus_req_o, 0);
        tick();
        chk("t1_breq_n1", ifc.bus_req_o, 1);
        chk("t1_addr_n1", ifc.bus_addr_o, 32'h100);
        chk("t1_stall_n1", ifc.stall_o, STALL_IF);
        chk("t1_ack_n1", ifc.if_ack_o, 0);
        tick();
        chk("t1_ack_n2", ifc.if_ack_o, 1);
        chk("t1_rdata_n2", ifc.if_rdata_o, 32'h3C01ABCD);
        chk("t1_stall_n2", ifc.stall_o, STALL_NONE);
        chk("t1_breq_n2", ifc.bus_req_o, 0);
        ifc.if_req_i = 1'b0;
        tick();
        chk("t1_ack_n3", ifc.if_ack_o, 0);

        // Load with three wait states; the request address changes mid-cycle
        ifc.mem_req_i  = 1'b1;
        ifc.mem_we_i   = 1'b0;
        ifc.mem_sel_i  = 4'hF;
        ifc.mem_addr_i = 32'h40;
        slave_wait     = 3;
        slave_rdata    = 32'h12345678;
        tick();
        ifc.mem_addr_i = 32'hFFF0;
        for (int i = 0; i < 4; i++) begin
            chk("t3_breq", ifc.bus_req_o, 1);
            chk("t3_addr", ifc.bus_addr_o, 32'h40);
            chk("t3_ack_early", ifc.mem_ack_o, 0);
            tick();
        end
        chk("t3_ack", ifc.mem_ack_o, 1);
        chk("t3_rdata", ifc.mem_rdata_o, 32'h12345678);
        chk("t3_breq_done", ifc.bus_req_o, 0);
        ifc.mem_req_i = 1'b0;
        tick();
        chk("t3_ack_once", ifc.mem_ack_o, 0);

        // Stray ack in IDLE
        slave_wait = 0;
        stray_ack  = 1'b1;
        tick();
        stray_ack = 1'b0;
        chk("stray_rdata", ifc.mem_rdata_o, 32'h12345678);
        chk("stray_breq", ifc.bus_req_o, 0);
        chk("stray_ack", {ifc.if_ack_o, ifc.mem_ack_o}, 0);

        // Simultaneous requests: store wins, fetch deferred
        slave_rdata     = 32'hFFFFFFFF;
        ifc.mem_req_i   = 1'b1;
        ifc.mem_we_i    = 1'b1;
        ifc.mem_sel_i   = 4'hF;
        ifc.mem_addr_i  = 32'h2000;
        ifc.mem_wdata_i = 32'hDEADBEEF;
        ifc.if_req_i    = 1'b1;
        ifc.if_addr_i   = 32'h104;
        #1;
        chk("t2_stall0", ifc.stall_o, STALL_MEM);
        tick();
        chk("t2_we", ifc.bus_we_o, 1);
        chk("t2_addr", ifc.bus_addr_o, 32'h2000);
        chk("t2_wdata", ifc.bus_wdata_o, 32'hDEADBEEF);
        chk("t2_sel", ifc.bus_sel_o, 4'hF);
        chk("t2_stall1", ifc.stall_o, STALL_MEM);
        tick();
        chk("t2_mem_ack", ifc.mem_ack_o, 1);
        chk("t2_mem_rdata", ifc.mem_rdata_o, 0);
        chk("t2_if_ack_early", ifc.if_ack_o, 0);
        chk("t2_stall2", ifc.stall_o, STALL_IF);
        ifc.mem_req_i = 1'b0;
        slave_rdata   = 32'h00001111;
        tick();
        chk("t2_idle_breq", ifc.bus_req_o, 0);
        chk("t2_idle_stall", ifc.stall_o, STALL_IF);
        tick();
        chk("t2_if_we", ifc.bus_we_o, 0);
        chk("t2_if_addr", ifc.bus_addr_o, 32'h104);
        tick();
        chk("t2_if_ack", ifc.if_ack_o, 1);
        chk("t2_if_rdata", ifc.if_rdata_o, 32'h00001111);
        ifc.if_req_i = 1'b0;
        tick();

        // Dead slave triggers the watchdog
        slave_dead    = 1'b1;
        ifc.if_req_i  = 1'b1;
        ifc.if_addr_i = 32'h200;
        tick();
        n = 0;
        while (ifc.bus_req_o && n < 40) begin
            n++;
            tick();
        end
        chk("t4_busy_cycles", n, 15);
        chk("t4_err", ifc.bus_err_o, 1);
        chk("t4_if_ack", ifc.if_ack_o, 1);
        chk("t4_if_rdata", ifc.if_rdata_o, 0);
        chk("t4_breq", ifc.bus_req_o, 0);
        ifc.if_req_i = 1'b0;
        slave_dead   = 1'b0;
        tick();
        chk("t4_err_pulse", ifc.bus_err_o, 0);
        ifc.mem_req_i  = 1'b1;
        ifc.mem_we_i   = 1'b0;
        ifc.mem_addr_i = 32'h44;
        slave_rdata    = 32'hCAFE0001;
        tick();
        tick();
        chk("t4_resume_ack", ifc.mem_ack_o, 1);
        chk("t4_resume_rdata", ifc.mem_rdata_o, 32'hCAFE0001);
        ifc.mem_req_i = 1'b0;
        tick();

        // Reset during BUSY, then re-grant of the held fetch
        slave_wait    = 5;
        slave_rdata   = 32'h55AA55AA;
        ifc.if_req_i  = 1'b1;
        ifc.if_addr_i = 32'h300;
        tick();
        tick();
        chk("t5_busy", ifc.bus_req_o, 1);
        rst = 1'b0;
        #1;
        chk("t5_rst_breq", ifc.bus_req_o, 0);
        chk("t5_rst_stall", ifc.stall_o, STALL_NONE);
        chk("t5_rst_acks", {ifc.if_ack_o, ifc.mem_ack_o}, 0);
        tick();
        rst = 1'b1;
        #1;
        chk("t5_rel_stall", ifc.stall_o, STALL_IF);
        tick();
        chk("t5_regrant", ifc.bus_req_o, 1);
        chk("t5_regrant_addr", ifc.bus_addr_o, 32'h300);
        n = 0;
        while (!ifc.if_ack_o && n < 20) begin
            tick();
            n++;
        end
        chk("t5_ack", ifc.if_ack_o, 1);
        chk("t5_rdata", ifc.if_rdata_o, 32'h55AA55AA);

        // Request still held through DONE: no second ack, no new bus cycle from DONE
        tick();
        chk("t6_no_dup_ack", ifc.if_ack_o, 0);
        chk("t6_no_grant_done", ifc.bus_req_o, 0);
        ifc.if_req_i = 1'b0;
        tick();
        chk("t6_no_dup_cycle", ifc.bus_req_o, 0);
        chk("t6_stall_idle", ifc.stall_o, STALL_NONE);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
